// File: rtl/sram_arbiter_if.sv
// Purpose: bundles the CPU port (C_*), auxiliary port (D_*) and SRAM pin signals of sram_arbiter.
// Latency: none, wiring only.
// Backpressure: none here; requesters hold req until the matching ack.
//
// Modports:
//   slave  - the arbiter: samples requests and Data_from_SRAM, drives acks, rdata, SRAM controls.
//   master - the requesters plus board SRAM: drive requests and Data_from_SRAM, observe the rest.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    // CPU port
    logic              C_req;
    logic              C_we;
    logic [ADDR_W-1:0] C_addr;
    logic [DATA_W-1:0] C_wdata;
    logic [DATA_W-1:0] C_rdata;
    logic              C_ack;

    // Auxiliary port
    logic              D_req;
    logic              D_we;
    logic [ADDR_W-1:0] D_addr;
    logic [DATA_W-1:0] D_wdata;
    logic [DATA_W-1:0] D_rdata;
    logic              D_ack;

    // SRAM pins, controls active-low
    logic              Mem_CE;
    logic              Mem_UB;
    logic              Mem_LB;
    logic              Mem_OE;
    logic              Mem_WE;
    logic [ADDR_W-1:0] Mem_ADDR;
    logic [DATA_W-1:0] Data_to_SRAM;
    logic [DATA_W-1:0] Data_from_SRAM;
    logic              Mem_Drive;

    // Status
    logic              Grant_D;
    logic              Busy;

    modport slave (
        input  C_req, C_we, C_addr, C_wdata,
        output C_rdata, C_ack,
        input  D_req, D_we, D_addr, D_wdata,
        output D_rdata, D_ack,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_ADDR, Data_to_SRAM, Mem_Drive,
        input  Data_from_SRAM,
        output Grant_D, Busy
    );

    modport master (
        output C_req, C_we, C_addr, C_wdata,
        input  C_rdata, C_ack,
        output D_req, D_we, D_addr, D_wdata,
        input  D_rdata, D_ack,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_ADDR, Data_to_SRAM, Mem_Drive,
        output Data_from_SRAM,
        input  Grant_D, Busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Purpose: shares one asynchronous 16-bit SRAM between the CPU (port C) and an aux master (port D).
// Latency: req sampled in IDLE -> strobes low for WAIT_CYC cycles -> one-cycle ack WAIT_CYC+1 cycles later.
// Backpressure: requesters hold req and inputs until ack; a losing or late request simply waits in IDLE.
//
// Ports:
//   Clk, Reset          - clock, asynchronous active-high reset
//   bus (slave modport) - C_*/D_* request ports, SRAM pins (Mem_*, Data_*), Grant_D, Busy
// Build option: define SRAM_ARB_RR_EN for round-robin on simultaneous requests
// (default is fixed priority with the CPU winning ties).
// Every output is a flop; nothing combinational reaches the pins from the request inputs.
module sram_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2      // strobe cycles per access, 1..15
) (
    input  logic          Clk,
    input  logic          Reset,
    sram_arbiter_if.slave bus
);
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Latched access
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_q;

    // Read data returned to each port
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Registered pin/status values
    logic              ce_q, oe_q, we_n_q, drive_q;
    logic              c_ack_q, d_ack_q, busy_q;

    // Next-state side
    logic              load;
    logic              capture;
    logic              pick_d;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              nxt_we;
    logic              strobe_on;
    logic              ce_d, oe_d, we_n_d, drive_d;
    logic              c_ack_d, d_ack_d, busy_d;

    // ------------------------------------------------------------------
    // Arbitration: pick_d is only meaningful when at least one req is high.
    // ------------------------------------------------------------------
`ifdef SRAM_ARB_RR_EN
    // Port that won the previous grant. Resets to D so the CPU takes the first tie.
    logic last_d_q;

    always_comb begin
        if (bus.C_req && bus.D_req) begin
            pick_d = ~last_d_q;
        end else begin
            pick_d = ~bus.C_req;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_d_q <= 1'b1;
        end else if (load) begin
            last_d_q <= pick_d;
        end
    end
`else
    assign pick_d = ~bus.C_req;
`endif

    assign win_we    = pick_d ? bus.D_we    : bus.C_we;
    assign win_addr  = pick_d ? bus.D_addr  : bus.C_addr;
    assign win_wdata = pick_d ? bus.D_wdata : bus.C_wdata;

    // ------------------------------------------------------------------
    // Next state and next pin values. The pins are registered, so they are
    // computed here from state_d: they change on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.C_req || bus.D_req) begin
                    load    = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    capture = ~we_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // On the granting edge the latched we is not yet updated.
        nxt_we    = load ? win_we : we_q;
        strobe_on = (state_d == ACCESS);

        ce_d    = ~strobe_on;
        oe_d    = ~(strobe_on && !nxt_we);
        we_n_d  = ~(strobe_on && nxt_we);
        drive_d = strobe_on && nxt_we;

        // DONE is only entered from ACCESS, so grant_q already names the winner.
        c_ack_d = (state_d == DONE) && !grant_q;
        d_ack_d = (state_d == DONE) &&  grant_q;
        busy_d  = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // State, latches and pin registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_q   <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_n_q    <= 1'b1;
            drive_q   <= 1'b0;
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;

            if (load) begin
                we_q    <= win_we;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                grant_q <= pick_d;
            end

            // Last ACCESS edge: the SRAM has had WAIT_CYC cycles of OE low.
            if (capture) begin
                if (grant_q) begin
                    d_rdata_q <= bus.Data_from_SRAM;
                end else begin
                    c_rdata_q <= bus.Data_from_SRAM;
                end
            end

            ce_q    <= ce_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
            drive_q <= drive_d;
            c_ack_q <= c_ack_d;
            d_ack_q <= d_ack_d;
            busy_q  <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Pins
    // ------------------------------------------------------------------
    // Byte lanes are always accessed as a full 16-bit word.
    assign bus.Mem_CE       = ce_q;
    assign bus.Mem_UB       = ce_q;
    assign bus.Mem_LB       = ce_q;
    assign bus.Mem_OE       = oe_q;
    assign bus.Mem_WE       = we_n_q;
    assign bus.Mem_Drive    = drive_q;
    assign bus.Mem_ADDR     = addr_q;
    assign bus.Data_to_SRAM = wdata_q;

    assign bus.C_rdata = c_rdata_q;
    assign bus.C_ack   = c_ack_q;
    assign bus.D_rdata = d_rdata_q;
    assign bus.D_ack   = d_ack_q;
    assign bus.Grant_D = grant_q;
    assign bus.Busy    = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: unit 0 built with WAIT_CYC=2, unit 1 with WAIT_CYC=1.
// Stimulus pushes expected accesses into a per-unit queue; a negedge monitor checks
// every strobe cycle and every ack against the front of the queue.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd;
        int          ack_cyc;
    } exp_t;

    logic       Clk = 1'b0;
    logic [1:0] rst;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    exp_t       sbq [2][$];
    int         scnt [2];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(2)) dut0 (
        .Clk   (Clk),
        .Reset (rst[0]),
        .bus   (bus0.slave)
    );
    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1)) dut1 (
        .Clk   (Clk),
        .Reset (rst[1]),
        .bus   (bus1.slave)
    );

    // Mirrors so the monitor can loop over both units
    logic [1:0]    ce, ub, lb, oe, we_n, drv, cack, dack, gnt, busy;
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] mdout [2];
    logic [DW-1:0] crd   [2];
    logic [DW-1:0] drd   [2];

    assign ce    = {bus1.Mem_CE,    bus0.Mem_CE};
    assign ub    = {bus1.Mem_UB,    bus0.Mem_UB};
    assign lb    = {bus1.Mem_LB,    bus0.Mem_LB};
    assign oe    = {bus1.Mem_OE,    bus0.Mem_OE};
    assign we_n  = {bus1.Mem_WE,    bus0.Mem_WE};
    assign drv   = {bus1.Mem_Drive, bus0.Mem_Drive};
    assign cack  = {bus1.C_ack,     bus0.C_ack};
    assign dack  = {bus1.D_ack,     bus0.D_ack};
    assign gnt   = {bus1.Grant_D,   bus0.Grant_D};
    assign busy  = {bus1.Busy,      bus0.Busy};
    assign maddr[0] = bus0.Mem_ADDR;      assign maddr[1] = bus1.Mem_ADDR;
    assign mdout[0] = bus0.Data_to_SRAM;  assign mdout[1] = bus1.Data_to_SRAM;
    assign crd[0]   = bus0.C_rdata;       assign crd[1]   = bus1.C_rdata;
    assign drd[0]   = bus0.D_rdata;       assign drd[1]   = bus1.D_rdata;

    function automatic int wc(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    // Unwritten locations read back as 0xA5 followed by the low address byte.
    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {8'hA5, a[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // SRAM models, evaluated away from the clock edge
    logic [DW-1:0] mem0 [logic [AW-1:0]];
    logic [DW-1:0] mem1 [logic [AW-1:0]];

    always @(negedge Clk) begin
        if (!bus0.Mem_CE && !bus0.Mem_WE) mem0[bus0.Mem_ADDR] = bus0.Data_to_SRAM;
        if (!bus1.Mem_CE && !bus1.Mem_WE) mem1[bus1.Mem_ADDR] = bus1.Data_to_SRAM;
        if (!bus0.Mem_OE)
            bus0.Data_from_SRAM = mem0.exists(bus0.Mem_ADDR) ? mem0[bus0.Mem_ADDR] : dflt(bus0.Mem_ADDR);
        else
            bus0.Data_from_SRAM = '0;
        if (!bus1.Mem_OE)
            bus1.Data_from_SRAM = mem1.exists(bus1.Mem_ADDR) ? mem1[bus1.Mem_ADDR] : dflt(bus1.Mem_ADDR);
        else
            bus1.Data_from_SRAM = '0;
    end

    // Monitor / scoreboard
    always @(negedge Clk) begin : mon
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            if (rst[u] === 1'b0) begin
                if (ce[u] == 1'b0) begin
                    if (sbq[u].size() == 0) begin
                        chk("strobe_unexpected", 1, 0);
                    end else begin
                        e = sbq[u][0];
                        scnt[u]++;
                        chk("strobe_pins",
                            {ub[u], lb[u], oe[u], we_n[u], drv[u], maddr[u], (e.we ? mdout[u] : 16'h0)},
                            {2'b00, e.we, !e.we, e.we, e.addr, (e.we ? e.wdata : 16'h0)});
                    end
                end
                if (cack[u] || dack[u]) begin
                    if (sbq[u].size() == 0) begin
                        chk("ack_unexpected", 1, 0);
                    end else begin
                        e = sbq[u].pop_front();
                        chk("ack_port", {cack[u], dack[u], gnt[u]}, {!e.is_d, e.is_d, e.is_d});
                        chk("ack_cycle", cyc, e.ack_cyc);
                        chk("strobe_len", scnt[u], wc(u));
                        chk("done_pins", {ce[u], oe[u], we_n[u], drv[u], busy[u]}, 5'b11101);
                        if (!e.we) chk("rdata", e.is_d ? drd[u] : crd[u], e.rd);
                    end
                    scnt[u] = 0;
                end
            end
        end
    end

    task automatic set_req(input int u, input bit is_d, input bit req, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        case ({u[0], is_d})
            2'b00: begin bus0.C_req = req; bus0.C_we = we; bus0.C_addr = a; bus0.C_wdata = d; end
            2'b01: begin bus0.D_req = req; bus0.D_we = we; bus0.D_addr = a; bus0.D_wdata = d; end
            2'b10: begin bus1.C_req = req; bus1.C_we = we; bus1.C_addr = a; bus1.C_wdata = d; end
            default: begin bus1.D_req = req; bus1.D_we = we; bus1.D_addr = a; bus1.D_wdata = d; end
        endcase
    endtask

    task automatic expect_acc(input int u, input bit is_d, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int ack_cyc);
        exp_t e;
        e.is_d = is_d; e.we = we; e.addr = a; e.wdata = wd; e.rd = rd; e.ack_cyc = ack_cyc;
        sbq[u].push_back(e);
    endtask

    // Raise req now (a negedge), hold until n_acks acks, drop req at the last ack.
    task automatic drive(input int u, input bit is_d, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int n_acks);
        int got;
        int waited;
        got = 0;
        waited = 0;
        set_req(u, is_d, 1'b1, we, a, d);
        while (got < n_acks && waited < 60) begin
            @(negedge Clk);
            waited++;
            if (is_d ? dack[u] : cack[u]) got++;
        end
        if (got < n_acks) chk("req_timeout", got, n_acks);
        set_req(u, is_d, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        rst = 2'b11;
        scnt[0] = 0;
        scnt[1] = 0;
        for (int u = 0; u < 2; u++)
            for (int p = 0; p < 2; p++) set_req(u, p[0], 1'b0, 1'b0, '0, '0);
        cycles(2);

        // Reset values
        for (int u = 0; u < 2; u++) begin
            chk("rst_strobes", {ce[u], ub[u], lb[u], oe[u], we_n[u]}, 5'h1F);
            chk("rst_status", {drv[u], cack[u], dack[u], busy[u], gnt[u]}, 5'h00);
            chk("rst_data", {maddr[u], mdout[u], crd[u], drd[u]}, 0);
        end
        rst = 2'b00;
        cycles(1);

        // CPU write 0x00010 <- 0xBEEF
        t0 = cyc;
        expect_acc(0, 0, 1, 20'h00010, 16'hBEEF, 16'h0, t0 + 3);
        drive(0, 0, 1, 20'h00010, 16'hBEEF, 1);
        cycles(1);

        // CPU read back, then rdata must hold
        t0 = cyc;
        expect_acc(0, 0, 0, 20'h00010, 16'h0, 16'hBEEF, t0 + 3);
        drive(0, 0, 0, 20'h00010, 16'h0, 1);
        cycles(2);
        chk("c_rdata_hold", crd[0], 16'hBEEF);

        // Simultaneous reads: CPU first in both builds (reset last-grant is D)
        t0 = cyc;
        expect_acc(0, 0, 0, 20'h00020, 16'h0, 16'hA520, t0 + 3);
        expect_acc(0, 1, 0, 20'h00031, 16'h0, 16'hA531, t0 + 7);
        fork
            drive(0, 0, 0, 20'h00020, 16'h0, 1);
            drive(0, 1, 0, 20'h00031, 16'h0, 1);
        join
        chk("c_rdata_hold2", crd[0], 16'hA520);
        cycles(1);

        // CPU-only read, then another tie: RR build gives it to D
        t0 = cyc;
        expect_acc(0, 0, 0, 20'h00040, 16'h0, 16'hA540, t0 + 3);
        drive(0, 0, 0, 20'h00040, 16'h0, 1);
        cycles(1);
        t0 = cyc;
`ifdef SRAM_ARB_RR_EN
        expect_acc(0, 1, 0, 20'h00060, 16'h0, 16'hA560, t0 + 3);
        expect_acc(0, 0, 0, 20'h00050, 16'h0, 16'hA550, t0 + 7);
`else
        expect_acc(0, 0, 0, 20'h00050, 16'h0, 16'hA550, t0 + 3);
        expect_acc(0, 1, 0, 20'h00060, 16'h0, 16'hA560, t0 + 7);
`endif
        fork
            drive(0, 0, 0, 20'h00050, 16'h0, 1);
            drive(0, 1, 0, 20'h00060, 16'h0, 1);
        join
        cycles(1);

        // D write in flight, C arrives one cycle later and reads what D wrote
        t0 = cyc;
        expect_acc(0, 1, 1, 20'h00123, 16'h5A5A, 16'h0, t0 + 3);
        expect_acc(0, 0, 0, 20'h00123, 16'h0, 16'h5A5A, t0 + 7);
        fork
            drive(0, 1, 1, 20'h00123, 16'h5A5A, 1);
            begin
                cycles(1);
                drive(0, 0, 0, 20'h00123, 16'h0, 1);
            end
        join
        chk("d_rdata_hold", drd[0], 16'hA560);
        cycles(1);

        // Reset in the second strobe cycle of a write
        t0 = cyc;
        expect_acc(0, 0, 1, 20'h00077, 16'h1234, 16'h0, t0 + 3);
        set_req(0, 0, 1'b1, 1'b1, 20'h00077, 16'h1234);
        cycles(2);
        chk("pre_reset_we", we_n[0], 1'b0);
        #2;
        rst[0] = 1'b1;
        sbq[0].delete();
        scnt[0] = 0;
        #1;
        chk("reset_abort", {ce[0], we_n[0], drv[0], busy[0], cack[0]}, 5'b11000);
        set_req(0, 0, 1'b0, 1'b0, '0, '0);
        cycles(2);
        rst[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            chk("no_ack_after_reset", {cack[0], dack[0], busy[0]}, 3'b000);
        end

        // Re-issued write completes, then read back
        t0 = cyc;
        expect_acc(0, 0, 1, 20'h00077, 16'h1234, 16'h0, t0 + 3);
        drive(0, 0, 1, 20'h00077, 16'h1234, 1);
        cycles(1);
        t0 = cyc;
        expect_acc(0, 0, 0, 20'h00077, 16'h0, 16'h1234, t0 + 3);
        drive(0, 0, 0, 20'h00077, 16'h0, 1);
        cycles(1);

        // WAIT_CYC=1: three back-to-back reads with req held high
        t0 = cyc;
        expect_acc(1, 0, 0, 20'h000A0, 16'h0, 16'hA5A0, t0 + 2);
        expect_acc(1, 0, 0, 20'h000A0, 16'h0, 16'hA5A0, t0 + 5);
        expect_acc(1, 0, 0, 20'h000A0, 16'h0, 16'hA5A0, t0 + 8);
        drive(1, 0, 0, 20'h000A0, 16'h0, 3);
        cycles(1);

        // WAIT_CYC=1 aux write then aux read
        t0 = cyc;
        expect_acc(1, 1, 1, 20'h000A1, 16'hC0DE, 16'h0, t0 + 2);
        drive(1, 1, 1, 20'h000A1, 16'hC0DE, 1);
        cycles(1);
        t0 = cyc;
        expect_acc(1, 1, 0, 20'h000A1, 16'h0, 16'hC0DE, t0 + 2);
        drive(1, 1, 0, 20'h000A1, 16'h0, 1);
        cycles(3);

        chk("sb_empty0", sbq[0].size(), 0);
        chk("sb_empty1", sbq[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
